// File: rtl/intc_priority.sv
// Fixed-priority interrupt controller with INTMASK/INTPEND/INTIV MMRs and CPU handshake FSM.
// Latency: request to INTREQ one MCLK; INTACK to CLR pulse one MCLK, back in IDLE two MCLKs later.
// No backpressure: requests are level-held by sources; INTACK is honoured only while INTREQ is high.
module intc_priority #(
  parameter logic [15:0] START     = 16'h0140,
  parameter int          SRC_COUNT = 8,
  parameter logic [15:0] VEC_BASE  = 16'hFFE0
) (
  input  logic                 MCLK,
  input  logic                 reset,
  input  logic [15:0]          MAB,
  input  logic [15:0]          MDBwrite,
  input  logic                 MW,
  input  logic                 BW,
  output logic [15:0]          MDBread,
  input  logic [SRC_COUNT-1:0] IRQ,
  input  logic                 GIE,
  input  logic                 INTACK,
  output logic                 INTREQ,
  output logic [15:0]          INTVEC,
  output logic [SRC_COUNT-1:0] CLR
);

  localparam logic [15:0] A_MASK = START;
  localparam logic [15:0] A_PEND = START + 16'd2;
  localparam logic [15:0] A_IV   = START + 16'd4;

  typedef enum logic [1:0] {IDLE, PEND, ACK, GUARD} state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [3:0]             r_idx;
  logic [3:0]             w_idx_next;
  logic [SRC_COUNT-1:0]   r_mask;

  logic [SRC_COUNT-1:0]   w_pend;
  logic                   w_any;
  logic [3:0]             w_win;
  logic [4:0]             w_win_p1;
  logic [15:0]            w_iv;
  logic [15:0]            w_mask16;
  logic [15:0]            w_mask_wr16;
  logic                   w_sel_mask;
  logic                   w_sel_pend;
  logic                   w_sel_iv;
  logic [15:0]            w_pend16;

  assign w_pend     = IRQ & r_mask;
  assign w_any      = |w_pend;
  assign w_sel_mask = (MAB[15:1] == A_MASK[15:1]);
  assign w_sel_pend = (MAB[15:1] == A_PEND[15:1]);
  assign w_sel_iv   = (MAB[15:1] == A_IV[15:1]);

  // Highest set index of the masked requests wins; later iterations override earlier ones.
  always_comb begin
    w_win = 4'd0;
    for (int i = 0; i < SRC_COUNT; i++) begin
      if (w_pend[i]) w_win = 4'(i);
    end
  end

  assign w_win_p1 = {1'b0, w_win} + 5'd1;
  assign w_iv     = w_any ? {10'd0, w_win_p1, 1'b0} : 16'h0000;

  // Zero-extend mask and pending vectors to the 16-bit data bus.
  always_comb begin
    w_mask16                  = 16'h0000;
    w_mask16[SRC_COUNT-1:0]   = r_mask;
    w_pend16                  = 16'h0000;
    w_pend16[SRC_COUNT-1:0]   = w_pend;
  end

  // Merge write data with the current mask; byte writes take their data from the low lane.
  always_comb begin
    w_mask_wr16 = MDBwrite;
    if (BW) begin
      if (MAB[0]) w_mask_wr16 = {MDBwrite[7:0], w_mask16[7:0]};
      else        w_mask_wr16 = {w_mask16[15:8], MDBwrite[7:0]};
    end
  end

  // INTMASK register; unimplemented upper bits are simply never stored.
  always_ff @(posedge MCLK or negedge reset) begin
    if (!reset) begin
      r_mask <= '0;
    end else if (MW && w_sel_mask) begin
      r_mask <= w_mask_wr16[SRC_COUNT-1:0];
    end
  end

  // Combinational read mux; unmapped addresses read zero.
  always_comb begin
    MDBread = 16'h0000;
    if (w_sel_mask)      MDBread = w_mask16;
    else if (w_sel_pend) MDBread = w_pend16;
    else if (w_sel_iv)   MDBread = w_iv;
  end

  // Handshake state and latched winning index.
  always_ff @(posedge MCLK or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_idx   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
    end
  end

  // Next-state logic: acknowledge beats withdrawal; while pending, track the current winner.
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    case (r_state)
      IDLE: begin
        if (GIE && w_any) begin
          w_state_next = PEND;
          w_idx_next   = w_win;
        end
      end
      PEND: begin
        if (INTACK) begin
          w_state_next = ACK;
        end else if (!GIE || !w_any) begin
          w_state_next = IDLE;
        end else begin
          w_idx_next = w_win;
        end
      end
      ACK:     w_state_next = GUARD;
      GUARD:   w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  assign INTREQ = (r_state == PEND);
  assign INTVEC = (r_state == PEND) ? (VEC_BASE + {11'd0, r_idx, 1'b0}) : 16'h0000;

  // One-hot clear pulse for the acknowledged source while in ACK.
  always_comb begin
    CLR = '0;
    for (int i = 0; i < SRC_COUNT; i++) begin
      CLR[i] = (r_state == ACK) && (r_idx == 4'(i));
    end
  end

endmodule

// File: tb/tb_intc_priority.sv
// Self-checking bench for intc_priority: vector table, handshake corner sequences,
// a small TimerA flag model on source 7, and randomized traffic against a reference model.
module tb_intc_priority;

  localparam logic [15:0] START    = 16'h0140;
  localparam logic [15:0] VEC_BASE = 16'hFFE0;

  logic        MCLK;
  logic        reset;
  logic [15:0] MAB;
  logic [15:0] MDBwrite;
  logic        MW;
  logic        BW;
  logic [15:0] MDBread;
  logic [7:0]  IRQ;
  logic        GIE;
  logic        INTACK;
  logic        INTREQ;
  logic [15:0] INTVEC;
  logic [7:0]  CLR;

  logic [7:0]  irq_drv;
  logic        tmr_en;
  logic [4:0]  tmr_cnt;
  logic        tmr_flag;

  int n_chk;
  int n_fail;

  assign IRQ = tmr_en ? {tmr_flag, irq_drv[6:0]} : irq_drv;

  intc_priority #(.START(START), .SRC_COUNT(8), .VEC_BASE(VEC_BASE)) dut (
    .MCLK(MCLK), .reset(reset), .MAB(MAB), .MDBwrite(MDBwrite), .MW(MW), .BW(BW),
    .MDBread(MDBread), .IRQ(IRQ), .GIE(GIE), .INTACK(INTACK), .INTREQ(INTREQ),
    .INTVEC(INTVEC), .CLR(CLR)
  );

  initial MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  // TimerA in up mode, CCR0=19, CCIE=1: flag raised when the counter wraps, cleared by TAxCLR0.
  always @(posedge MCLK or negedge reset) begin
    if (!reset) begin
      tmr_cnt  <= 5'd0;
      tmr_flag <= 1'b0;
    end else begin
      if (tmr_en) tmr_cnt <= (tmr_cnt == 5'd19) ? 5'd0 : tmr_cnt + 5'd1;
      if (CLR[7]) tmr_flag <= 1'b0;
      if (tmr_en && tmr_cnt == 5'd19) tmr_flag <= 1'b1;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]  mask;
    logic [7:0]  irq;
    logic        gie;
    logic [7:0]  pend;
    logic [15:0] iv;
    logic        req;
    logic [15:0] vec;
  } vec_t;

  vec_t tbl [6];

  // Reference model state: phase 0=idle 1=pending 2=acknowledge 3=guard.
  int         m_phase;
  int         m_idx;
  logic [7:0] m_mask;

  function automatic int hi(input logic [7:0] v);
    int r;
    r = -1;
    for (int i = 0; i < 8; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge MCLK);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d, input logic bw);
    MAB = a; MDBwrite = d; BW = bw; MW = 1'b1;
    tick();
    MW = 1'b0; BW = 1'b0; MAB = 16'h0000; MDBwrite = 16'h0000;
  endtask

  task automatic do_reset();
    irq_drv = 8'h00; GIE = 1'b0; INTACK = 1'b0; MW = 1'b0; BW = 1'b0; tmr_en = 1'b0;
    MAB = 16'h0000; MDBwrite = 16'h0000;
    @(negedge MCLK) reset = 1'b0;
    @(negedge MCLK) reset = 1'b1;
    tick();
  endtask

  initial begin
    logic [7:0]  clr_acc;
    logic        req_acc;
    logic [15:0] addr, d, exp_rd, word;
    logic [7:0]  pend;
    int          k, to;
    logic        s_mw, s_bw, s_ack, s_gie;

    n_chk = 0; n_fail = 0;
    reset = 1'b0; irq_drv = 8'h00; GIE = 1'b0; INTACK = 1'b0; MW = 1'b0; BW = 1'b0;
    MAB = 16'h0000; MDBwrite = 16'h0000; tmr_en = 1'b0;

    tbl[0] = '{8'hFF, 8'h05, 1'b1, 8'h05, 16'd6,  1'b1, 16'hFFE4};
    tbl[1] = '{8'h0F, 8'hF0, 1'b1, 8'h00, 16'd0,  1'b0, 16'h0000};
    tbl[2] = '{8'hFF, 8'h80, 1'b1, 8'h80, 16'd16, 1'b1, 16'hFFEE};
    tbl[3] = '{8'hFF, 8'h01, 1'b0, 8'h01, 16'd2,  1'b0, 16'h0000};
    tbl[4] = '{8'h3C, 8'hFF, 1'b1, 8'h3C, 16'd12, 1'b1, 16'hFFEA};
    tbl[5] = '{8'h01, 8'h01, 1'b1, 8'h01, 16'd2,  1'b1, 16'hFFE0};

    // Held in reset with requests present: everything stays quiet.
    irq_drv = 8'hFF; GIE = 1'b1; INTACK = 1'b1; MAB = START;
    repeat (3) @(negedge MCLK);
    chk("rst_intreq", {31'd0, INTREQ}, 32'd0);
    chk("rst_intvec", {16'd0, INTVEC}, 32'd0);
    chk("rst_clr", {24'd0, CLR}, 32'd0);
    chk("rst_mask", {16'd0, MDBread}, 32'd0);
    do_reset();

    // Mask readback, byte writes.
    wr(START, 16'h00FF, 1'b0);
    MAB = START; #1;
    chk("mask_word", {16'd0, MDBread}, 32'h00FF);
    wr(START + 16'd1, 16'h0F0F, 1'b1);
    MAB = START; #1;
    chk("mask_byte_hi", {16'd0, MDBread}, 32'h00FF);
    wr(START, 16'h3C3C, 1'b1);
    MAB = START + 16'd1; #1;
    chk("mask_byte_lo", {16'd0, MDBread}, 32'h003C);
    wr(START + 16'd2, 16'hFFFF, 1'b0);
    wr(16'h0200, 16'hFFFF, 1'b0);
    MAB = START; #1;
    chk("mask_ro_unmapped", {16'd0, MDBread}, 32'h003C);
    MAB = 16'h0200; #1;
    chk("unmapped_read", {16'd0, MDBread}, 32'h0000);

    // Vector table.
    for (int i = 0; i < 6; i++) begin
      do_reset();
      wr(START, {8'h00, tbl[i].mask}, 1'b0);
      irq_drv = tbl[i].irq; GIE = tbl[i].gie;
      MAB = START + 16'd2; #1;
      chk($sformatf("tbl%0d_pend", i), {16'd0, MDBread}, {24'd0, tbl[i].pend});
      MAB = START + 16'd4; #1;
      chk($sformatf("tbl%0d_iv", i), {16'd0, MDBread}, {16'd0, tbl[i].iv});
      tick();
      chk($sformatf("tbl%0d_req", i), {31'd0, INTREQ}, {31'd0, tbl[i].req});
      chk($sformatf("tbl%0d_vec", i), {16'd0, INTVEC}, {16'd0, tbl[i].vec});
    end

    // Higher-priority request replaces the latched one a cycle later.
    do_reset();
    wr(START, 16'h00FF, 1'b0);
    irq_drv = 8'h05; GIE = 1'b1;
    tick();
    chk("prio_req", {31'd0, INTREQ}, 32'd1);
    chk("prio_vec", {16'd0, INTVEC}, 32'hFFE4);
    irq_drv = 8'h45; #1;
    chk("prio_vec_hold", {16'd0, INTVEC}, 32'hFFE4);
    tick();
    chk("prio_vec_upd", {16'd0, INTVEC}, 32'hFFEC);

    // Acknowledge wins over simultaneous withdrawal and GIE fall.
    do_reset();
    wr(START, 16'h00FF, 1'b0);
    irq_drv = 8'h02; GIE = 1'b1;
    tick();
    chk("ack_vec", {16'd0, INTVEC}, 32'hFFE2);
    INTACK = 1'b1; irq_drv = 8'h00; GIE = 1'b0;
    tick();
    INTACK = 1'b0;
    chk("ack_clr", {24'd0, CLR}, 32'h02);
    chk("ack_intreq", {31'd0, INTREQ}, 32'd0);
    irq_drv = 8'h02; GIE = 1'b1;
    tick();
    chk("guard_clr", {24'd0, CLR}, 32'h00);
    chk("guard_intreq", {31'd0, INTREQ}, 32'd0);
    tick();
    chk("idle_intreq", {31'd0, INTREQ}, 32'd0);
    tick();
    chk("rearm_intreq", {31'd0, INTREQ}, 32'd1);

    // Withdrawal before acknowledge; GIE low blocks requests.
    do_reset();
    wr(START, 16'h00FF, 1'b0);
    irq_drv = 8'h08; GIE = 1'b1;
    tick();
    chk("wd_vec", {16'd0, INTVEC}, 32'hFFE6);
    irq_drv = 8'h00;
    tick();
    chk("wd_intreq", {31'd0, INTREQ}, 32'd0);
    clr_acc = CLR; req_acc = 1'b0;
    irq_drv = 8'h08; GIE = 1'b0;
    repeat (4) begin
      tick();
      clr_acc |= CLR; req_acc |= INTREQ;
    end
    chk("wd_clr", {24'd0, clr_acc}, 32'd0);
    chk("gie0_intreq", {31'd0, req_acc}, 32'd0);

    // Mask cleared while pending withdraws the request; later INTACK is ignored.
    do_reset();
    wr(START, 16'h00FF, 1'b0);
    irq_drv = 8'h08; GIE = 1'b1;
    tick();
    wr(START, 16'h0000, 1'b0);
    tick();
    chk("mclr_intreq", {31'd0, INTREQ}, 32'd0);
    INTACK = 1'b1;
    tick();
    INTACK = 1'b0;
    clr_acc = CLR;
    tick();
    clr_acc |= CLR;
    chk("mclr_clr", {24'd0, clr_acc}, 32'd0);

    // Reset asserted in ACK aborts immediately.
    do_reset();
    wr(START, 16'h00FF, 1'b0);
    irq_drv = 8'h10; GIE = 1'b1;
    tick();
    INTACK = 1'b1;
    @(posedge MCLK);
    reset = 1'b0;
    INTACK = 1'b0;
    MAB = START;
    #1;
    chk("rack_clr", {24'd0, CLR}, 32'd0);
    chk("rack_intreq", {31'd0, INTREQ}, 32'd0);
    chk("rack_intvec", {16'd0, INTVEC}, 32'd0);
    chk("rack_mask", {16'd0, MDBread}, 32'd0);
    @(negedge MCLK) reset = 1'b1;
    clr_acc = 8'h00; req_acc = 1'b0;
    repeat (4) begin
      tick();
      clr_acc |= CLR; req_acc |= INTREQ;
    end
    chk("rack_after_clr", {24'd0, clr_acc}, 32'd0);
    chk("rack_after_req", {31'd0, req_acc}, 32'd0);

    // TimerA CCIFG on source 7.
    do_reset();
    wr(START, 16'h0080, 1'b0);
    GIE = 1'b1; tmr_en = 1'b1;
    to = 0;
    while (!INTREQ && to < 60) begin
      tick();
      to++;
    end
    chk("tmr_timeout", {31'd0, INTREQ}, 32'd1);
    chk("tmr_vec", {16'd0, INTVEC}, 32'hFFEE);
    INTACK = 1'b1;
    tick();
    INTACK = 1'b0;
    chk("tmr_clr", {24'd0, CLR}, 32'h80);
    tick();
    chk("tmr_irq_drop", {31'd0, IRQ[7]}, 32'd0);
    tmr_en = 1'b0;

    // Randomized traffic against the reference model.
    do_reset();
    m_phase = 0; m_idx = 0; m_mask = 8'h00;
    for (int c = 0; c < 600; c++) begin
      irq_drv = 8'($urandom);
      GIE     = ($urandom_range(0, 3) != 0);
      INTACK  = ($urandom_range(0, 2) == 0);
      MW      = ($urandom_range(0, 5) == 0);
      BW      = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: addr = START;
        1: addr = START + 16'd1;
        2: addr = START + 16'd2;
        3: addr = START + 16'd3;
        4: addr = START + 16'd4;
        5: addr = START + 16'd6;
        6: addr = START - 16'd2;
        default: addr = 16'h0000;
      endcase
      d = 16'($urandom);
      if (BW) d = {d[7:0], d[7:0]};
      MAB = addr; MDBwrite = d;
      #1;
      pend = IRQ & m_mask;
      k    = hi(pend);
      word = {addr[15:1], 1'b0};
      if (word == START)               exp_rd = {8'h00, m_mask};
      else if (word == START + 16'd2)  exp_rd = {8'h00, pend};
      else if (word == START + 16'd4)  exp_rd = (k < 0) ? 16'h0000 : 16'(2 * (k + 1));
      else                             exp_rd = 16'h0000;
      chk("rnd_rd", {16'd0, MDBread}, {16'd0, exp_rd});
      s_mw = MW; s_bw = BW; s_ack = INTACK; s_gie = GIE;
      @(posedge MCLK);
      case (m_phase)
        0: if (s_gie && k >= 0) begin m_phase = 1; m_idx = k; end
        1: begin
          if (s_ack) m_phase = 2;
          else if (!s_gie || k < 0) m_phase = 0;
          else m_idx = k;
        end
        2: m_phase = 3;
        default: m_phase = 0;
      endcase
      if (s_mw && word == START && (!s_bw || !addr[0])) m_mask = d[7:0];
      #1;
      chk("rnd_intreq", {31'd0, INTREQ}, (m_phase == 1) ? 32'd1 : 32'd0);
      chk("rnd_intvec", {16'd0, INTVEC}, (m_phase == 1) ? {16'd0, 16'(VEC_BASE + 16'(2 * m_idx))} : 32'd0);
      chk("rnd_clr", {24'd0, CLR}, (m_phase == 2) ? {24'd0, 8'(1 << m_idx)} : 32'd0);
    end
    MW = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
